// File: rtl/prim_truth_scanner_pkg.sv
// Shared definitions for the primitive truth-table scanner: four-state codes,
// FSM encoding and the helper that turns a resolved net into its code.
package prim_truth_scanner_pkg;

    localparam logic [1:0] FS_0 = 2'b00;
    localparam logic [1:0] FS_1 = 2'b01;
    localparam logic [1:0] FS_Z = 2'b10;
    localparam logic [1:0] FS_X = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_EMIT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic [1:0] fs_sense(input logic s);
        if (s === 1'bz) return FS_Z;
        if (s === 1'bx) return FS_X;
        return s ? FS_1 : FS_0;
    endfunction

endpackage

// File: rtl/prim_truth_scanner_if.sv
// Control and record-stream signals between the scanner and its controller/logger.
interface prim_truth_scanner_if #(
    parameter int N_IN = 3
) ();
    localparam int IDX_W = 2 * N_IN;

    logic               start;
    logic               busy;
    logic               done;
    logic               rec_valid;
    logic               rec_ready;
    logic [IDX_W+1:0]   rec_data;

    modport master (
        input  start,
        input  rec_ready,
        output busy,
        output done,
        output rec_valid,
        output rec_data
    );

    modport slave (
        output start,
        output rec_ready,
        input  busy,
        input  done,
        input  rec_valid,
        input  rec_data
    );
endinterface

// File: rtl/prim_truth_scanner_four_state_driver.sv
// Turns a two-bit four-state code into a real net value using a pair of tristate
// buffers; X is genuine strong-0/strong-1 contention, Z is both buffers off.
module four_state_driver
    import prim_truth_scanner_pkg::*;
(
    input  logic [1:0] i_code,
    output wire        o_net
);

    wire w_en_lo = (i_code == FS_0) || (i_code == FS_X);
    wire w_en_hi = (i_code == FS_1) || (i_code == FS_X);

    bufif1 u_drv_lo (o_net, 1'b0, w_en_lo);
    bufif1 u_drv_hi (o_net, 1'b1, w_en_hi);

endmodule

// File: rtl/prim_truth_scanner.sv
// Walks every four-state input vector onto a switch-level primitive, samples its
// output after a settle delay and streams {index, observed code} records.
//
//   state  | meaning
//   IDLE   | stim floating, waiting for start
//   DRIVE  | load stim codes from the vector index
//   SETTLE | let the primitive output resolve for SETTLE cycles
//   SAMPLE | capture the observed code into the record register
//   EMIT   | offer the record; advance or finish on acceptance
//   DONE   | one-cycle done pulse, stim released back to Z
module prim_truth_scanner
    import prim_truth_scanner_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    prim_truth_scanner_if.master bus,
    output wire  [N_IN-1:0]     stim,
    input  logic                obs
);

    localparam int IDX_W = 2 * N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = {IDX_W{1'b1}};

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_settle_cnt;
    logic [IDX_W-1:0]   r_stim_code;
    logic [IDX_W+1:0]   r_rec_data;

    state_t             w_next;
    logic               w_busy;
    logic               w_done;
    logic               w_valid;
    logic               w_last;
    logic               w_accept;

    assign w_last   = (r_idx == LAST_IDX);
    assign w_accept = w_valid & bus.rec_ready;

    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_DRIVE;
            end
            ST_DRIVE: begin
                w_busy = 1'b1;
                w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_busy = 1'b1;
                if (r_settle_cnt == '0) w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                w_busy = 1'b1;
                w_next = ST_EMIT;
            end
            ST_EMIT: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
                if (bus.rec_ready) w_next = w_last ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_settle_cnt <= '0;
            r_stim_code  <= {N_IN{FS_Z}};
            r_rec_data   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) r_idx <= '0;
                end
                ST_DRIVE: begin
                    r_stim_code  <= r_idx;
                    r_settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - CNT_W'(1);
                end
                ST_SAMPLE: begin
                    r_rec_data <= {r_idx, fs_sense(obs)};
                end
                ST_EMIT: begin
                    // The final index is held until the next start clears it.
                    if (w_accept && !w_last) r_idx <= r_idx + IDX_W'(1);
                end
                ST_DONE: begin
                    r_stim_code <= {N_IN{FS_Z}};
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_drv
        four_state_driver u_drv (
            .i_code (r_stim_code[2*gi+1:2*gi]),
            .o_net  (stim[gi])
        );
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.rec_valid = w_valid;
    assign bus.rec_data  = r_rec_data;

endmodule

// File: tb/tb_prim_truth_scanner.sv
// Directed bench: scanner driving an nmos model (obs = nmos(data=stim[0], gate=stim[1])).
module tb_prim_truth_scanner;

    logic       clk;
    logic       rst_n;
    wire  [1:0] stim;
    logic       obs;
    int         cyc;
    int         n_chk;
    int         n_err;
    logic       four_state;
    logic       fs_probe;
    logic [1:0] zz;
    int         n_rec;

    prim_truth_scanner_if #(.N_IN(2)) bus ();

    prim_truth_scanner #(.N_IN(2), .SETTLE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .stim  (stim),
        .obs   (obs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // nmos: gate on passes data, gate off floats, unknown gate gives X unless data floats
    always @* begin
        if (stim[1] === 1'b1)      obs = stim[0];
        else if (stim[1] === 1'b0) obs = 1'bz;
        else                       obs = (stim[0] === 1'bz) ? 1'bz : 1'bx;
    end

    function automatic logic [1:0] exp_code(input logic [3:0] idx);
        logic [1:0] g;
        logic [1:0] d;
        g = idx[3:2];
        d = idx[1:0];
        if (g == 2'b01) return d;
        if (g == 2'b00) return 2'b10;
        if (d == 2'b10) return 2'b10;
        return 2'b11;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_scan(input int stall_idx, input int spulse_idx, input int abort_idx,
                            output int nrec);
        int         last_acc;
        int         done_cnt;
        int         done_cyc;
        int         post;
        logic       finished;
        logic       aborted;
        logic       stalled;
        logic [5:0] rd;
        logic [5:0] rd_hold;
        logic [1:0] sd_hold;
        nrec = 0; last_acc = -1; done_cnt = 0; done_cyc = -1; post = 0;
        finished = 0; aborted = 0; stalled = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", {31'b0, bus.busy}, 32'd1);
        for (int c = 0; c < 300 && !finished; c++) begin
            bus.start = 1'b0;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                if (done_cnt == 1) bus.start = 1'b1;
            end
            if (bus.rec_valid) begin
                rd = bus.rec_data;
                if (int'(rd[5:2]) == abort_idx) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    check("abort_busy", {31'b0, bus.busy}, 32'd0);
                    check("abort_valid", {31'b0, bus.rec_valid}, 32'd0);
                    if (four_state) check("abort_stim_z", {30'b0, stim}, {30'b0, zz});
                    aborted = 1'b1;
                    finished = 1'b1;
                end else begin
                    if (int'(rd[5:2]) == stall_idx && !stalled) begin
                        bus.rec_ready = 1'b0;
                        rd_hold = rd;
                        sd_hold = stim;
                        repeat (5) begin
                            @(negedge clk);
                            check("stall_valid", {31'b0, bus.rec_valid}, 32'd1);
                            check("stall_data", {26'b0, bus.rec_data}, {26'b0, rd_hold});
                            check("stall_stim", {30'b0, stim}, {30'b0, sd_hold});
                        end
                        bus.rec_ready = 1'b1;
                        stalled = 1'b1;
                        last_acc = -1;
                    end
                    check("rec_idx", {28'b0, rd[5:2]}, nrec);
                    if (four_state) check("rec_code", {30'b0, rd[1:0]}, {30'b0, exp_code(rd[5:2])});
                    if (last_acc >= 0) check("rec_spacing", cyc - last_acc, 32'd5);
                    if (int'(rd[5:2]) == spulse_idx) bus.start = 1'b1;
                    last_acc = cyc;
                    nrec++;
                end
            end
            if (done_cnt > 0) begin
                post++;
                if (post == 3) finished = 1'b1;
            end
            if (!finished) @(negedge clk);
        end
        bus.start = 1'b0;
        check("scan_finished", {31'b0, finished}, 32'd1);
        if (aborted) begin
            repeat (3) @(negedge clk);
            check("abort_quiet", {30'b0, bus.rec_valid, bus.busy}, 32'd0);
        end else begin
            check("done_once", done_cnt, 32'd1);
            check("done_latency", done_cyc - last_acc, 32'd1);
            check("idle_after_done", {31'b0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        fs_probe = 1'bx;
        four_state = (fs_probe === 1'bx);
        zz = 2'bzz;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.rec_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_valid", {31'b0, bus.rec_valid}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_data", {26'b0, bus.rec_data}, 32'd0);
        if (four_state) check("rst_stim_z", {30'b0, stim}, {30'b0, zz});
        rst_n = 1'b1;
        @(negedge clk);

        // full scan, start pulsed while busy and again in the DONE cycle
        run_scan(-1, 5, -1, n_rec);
        check("scan_a_count", n_rec, 32'd16);
        if (four_state) check("idle_stim_z", {30'b0, stim}, {30'b0, zz});

        // backpressure at index 3, then reset while index 7 is offered
        @(negedge clk);
        run_scan(3, -1, 7, n_rec);
        check("scan_b_count", n_rec, 32'd7);

        // fresh scan after the abort restarts at index 0
        @(negedge clk);
        run_scan(-1, -1, -1, n_rec);
        check("scan_c_count", n_rec, 32'd16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
